// File: rtl/axis_sync_fifo_if.sv
// ============================================================================
// Module   : axis_sync_fifo_if
// Purpose  : AXI4-Stream beat bundle (data, valid, ready, last).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
// ============================================================================
// Module   : axis_sync_fifo
// Purpose  : Single-clock first-word-fall-through AXI4-Stream FIFO (data+last).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_DEPTH = 4
) (
    input  wire logic        aclk,
    input  wire logic        areset_n,
    axis_sync_fifo_if.slave  m,
    axis_sync_fifo_if.master s
);

    localparam int                  DEPTH   = 2 ** ADDR_DEPTH;
    localparam logic [ADDR_DEPTH:0] PTR_ONE = {{ADDR_DEPTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_DEPTH:0]   wr_ptr;
    logic [ADDR_DEPTH:0]   rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_DEPTH-1:0] == rd_ptr[ADDR_DEPTH-1:0]) &&
                   (wr_ptr[ADDR_DEPTH] != rd_ptr[ADDR_DEPTH]);

    // Gating with areset_n keeps the array untouched while reset is held.
    assign push = m.tvalid && !full && areset_n;
    assign pop  = s.tready && !empty;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[ADDR_DEPTH-1:0]] <= {m.tlast, m.tdata};
        end
    end

    assign m.tready            = !full;
    assign s.tvalid            = !empty;
    assign {s.tlast, s.tdata}  = mem[rd_ptr[ADDR_DEPTH-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
// ============================================================================
// Module   : tb_axis_sync_fifo
// Purpose  : Table-driven and scoreboard bench for axis_sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_sync_fifo;

    logic aclk;
    logic areset_n;

    axis_sync_fifo_if #(.DATA_WIDTH(8)) m_if ();
    axis_sync_fifo_if #(.DATA_WIDTH(8)) s_if ();

    axis_sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_DEPTH (4)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .m        (m_if),
        .s        (s_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [8:0] sb[$];
    logic [8:0] sb_head;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        logic       exp_rdy;
        logic       exp_val;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain(input string name);
        m_if.tvalid = 1'b0;
        s_if.tready = 1'b1;
        for (int k = 0; k < 40 && s_if.tvalid; k++) cycle();
        check({name, "_empty"}, 32'(s_if.tvalid), 32'd0);
        check({name, "_sb_left"}, 32'(sb.size()), 32'd0);
        s_if.tready = 1'b0;
    endtask

    // Handshakes are judged mid-cycle, where inputs and pointers are stable
    // ahead of the edge that will perform them.
    always @(negedge aclk) begin
        if (areset_n) begin
            if (s_if.tvalid && s_if.tready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected no beat", {s_if.tlast, s_if.tdata});
                end else begin
                    sb_head = sb.pop_front();
                    check("sb_data", 32'({s_if.tlast, s_if.tdata}), 32'(sb_head));
                end
            end
            if (m_if.tvalid && m_if.tready) sb.push_back({m_if.tlast, m_if.tdata});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   sent;
        int   pops_base;

        //            v     d      l     r     rdy   val
        vecs[0]  = '{1'b1, 8'h24, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'h32, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset held with valid asserted: nothing may be stored.
        areset_n    = 1'b0;
        m_if.tvalid = 1'b1;
        m_if.tdata  = 8'hEE;
        m_if.tlast  = 1'b1;
        s_if.tready = 1'b1;
        repeat (3) cycle();
        check("reset_s_tvalid", 32'(s_if.tvalid), 32'd0);
        check("reset_m_tready", 32'(m_if.tready), 32'd1);
        areset_n    = 1'b1;
        m_if.tvalid = 1'b0;
        s_if.tready = 1'b0;
        cycle();
        check("post_reset_s_tvalid", 32'(s_if.tvalid), 32'd0);
        check("post_reset_m_tready", 32'(m_if.tready), 32'd1);

        // Basic order and simultaneous push/pop at occupancy one.
        for (int i = 0; i < 11; i++) begin
            m_if.tvalid = vecs[i].v;
            m_if.tdata  = vecs[i].d;
            m_if.tlast  = vecs[i].l;
            s_if.tready = vecs[i].r;
            cycle();
            check($sformatf("vec%0d_m_tready", i), 32'(m_if.tready), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_s_tvalid", i), 32'(s_if.tvalid), 32'(vecs[i].exp_val));
        end
        check("basic_sb_left", 32'(sb.size()), 32'd0);

        // Fill to the full boundary.
        s_if.tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_if.tvalid = 1'b1;
            m_if.tdata  = 8'(i);
            m_if.tlast  = (i == 15);
            cycle();
            check($sformatf("fill%0d_m_tready", i), 32'(m_if.tready), (i < 15) ? 32'd1 : 32'd0);
        end
        check("fill_s_tvalid", 32'(s_if.tvalid), 32'd1);
        check("fill_head", 32'(s_if.tdata), 32'h00);
        m_if.tdata = 8'hAA;
        m_if.tlast = 1'b0;
        repeat (2) cycle();
        check("full_hold_m_tready", 32'(m_if.tready), 32'd0);

        m_if.tvalid = 1'b0;
        s_if.tready = 1'b1;
        cycle();
        check("pop_frees_m_tready", 32'(m_if.tready), 32'd1);
        check("pop_next_head", 32'(s_if.tdata), 32'h01);

        m_if.tvalid = 1'b1;
        m_if.tdata  = 8'h10;
        s_if.tready = 1'b0;
        cycle();
        check("refill_m_tready", 32'(m_if.tready), 32'd0);

        // Valid and ready together while full: only the pop may happen.
        m_if.tdata  = 8'hAB;
        s_if.tready = 1'b1;
        cycle();
        m_if.tvalid = 1'b0;
        check("full_both_m_tready", 32'(m_if.tready), 32'd1);
        check("full_both_head", 32'(s_if.tdata), 32'h02);
        drain("fill");

        // Wrap-around with constant valid and toggling ready.
        pops_base = pops;
        sent      = 0;
        for (int c = 0; c < 400 && sent < 40; c++) begin
            m_if.tvalid = 1'b1;
            m_if.tdata  = 8'(sent);
            m_if.tlast  = (sent % 8 == 7);
            s_if.tready = c[0];
            @(negedge aclk);
            acc = m_if.tready;
            @(posedge aclk);
            #1;
            if (acc) sent++;
        end
        check("wrap_sent", 32'(sent), 32'd40);
        drain("wrap");
        check("wrap_pop_count", 32'(pops - pops_base), 32'd40);

        // Asynchronous reset pulse mid-stream.
        s_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_if.tvalid = 1'b1;
            m_if.tdata  = 8'(8'h60 + i);
            m_if.tlast  = 1'b0;
            cycle();
        end
        m_if.tvalid = 1'b0;
        check("pre_reset_s_tvalid", 32'(s_if.tvalid), 32'd1);
        #1;
        areset_n = 1'b0;
        #1;
        check("async_reset_s_tvalid", 32'(s_if.tvalid), 32'd0);
        check("async_reset_m_tready", 32'(m_if.tready), 32'd1);
        sb.delete();
        areset_n = 1'b1;
        cycle();
        check("after_reset_empty", 32'(s_if.tvalid), 32'd0);
        m_if.tvalid = 1'b1;
        m_if.tdata  = 8'h5A;
        m_if.tlast  = 1'b1;
        cycle();
        m_if.tvalid = 1'b0;
        check("reset_first_valid", 32'(s_if.tvalid), 32'd1);
        check("reset_first_data", 32'({s_if.tlast, s_if.tdata}), 32'h15A);
        drain("reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
